uart_rx_frame_check: RTL
========================

Name: uart_rx_frame_check

Overview:
Sequential UART receive frame checker. It consumes oversample-resolved bits from the RX bit sampler, one strobe per bit, and assembles LSB-first data of runtime-selectable length. It accumulates parity on the fly, validates optional parity and 1 or 2 stop bits, and detects line break. It sits between the RX sampler and the RX FIFO/CSR block, and generalises the old combinational parity check to a full-frame, run-time-configurable checker.

Parameters:
MAX_WIDTH, 9, maximum data bits per frame; data_out width; legal 5..9
MIN_WIDTH, 5, minimum data bits per frame
EVEN, 0, par_type encoding for even parity
ODD, 1, par_type encoding for odd parity

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns to IDLE, no frame reported
bit_in  input  1  resolved RX line value, valid when bit_valid=1
bit_valid  input  1  one-cycle strobe per received bit period
data_len  input  4  data bits per frame, sampled at start bit
par_en  input  1  1 = parity bit present, sampled at start bit
par_type  input  1  EVEN/ODD, sampled at start bit
stop_two  input  1  1 = two stop bits, sampled at start bit
data_out  output  MAX_WIDTH  last received data, right-aligned, upper bits 0
data_valid  output  1  one-cycle pulse: frame complete
par_err  output  1  parity mismatch of reported frame, valid with data_valid
stop_err  output  1  any stop bit sampled 0, valid with data_valid
brk  output  1  break detected, valid with data_valid
busy  output  1  1 in every state except IDLE

Behaviour:
- Reset (rst_n=0, async): state IDLE; data_out=0; data_valid, par_err, stop_err, brk, busy=0; shift register, bit counter and parity accumulator cleared.
- All state changes happen only on cycles with bit_valid=1, except clear and reset.
- IDLE: bit_valid & bit_in=0 is the start bit. Latch data_len (clamped: <MIN_WIDTH -> MIN_WIDTH, >MAX_WIDTH -> MAX_WIDTH), par_en, par_type, stop_two. Clear the accumulator and counter, then go to DATA. bit_valid & bit_in=1 stays in IDLE.
- DATA: shift bit_in in LSB-first, XOR it into the running parity, and increment the counter. After the latched length of bits, go to PARITY if par_en, else STOP1.
- PARITY: with EVEN, error if bit_in != xor(data); with ODD, error if bit_in != ~xor(data). Latch the internal parity flag. Go to STOP1.
- STOP1: bit_in=0 sets the internal stop flag. Go to STOP2 if stop_two, else finish.
- STOP2: bit_in=0 sets the internal stop flag. Finish.
- Finish: on the cycle after the last stop strobe, data_valid=1 for exactly one cycle. data_out is updated and the flags presented on par_err/stop_err/brk in that same cycle; the state returns to IDLE.
- The error flags are 0 whenever data_valid=0. data_out holds until the next completed frame.
- Latency: last stop bit strobe to data_valid is 1 clk.
- brk=1 when all data bits are 0, the parity bit (if present) is 0, and STOP1 is 0. stop_err is also 1 in that case.
- A new start bit is accepted in the cycle data_valid is high: IDLE is re-entered at the finish edge, so the next strobe is evaluated in IDLE.
- clear has priority over bit_valid in the same cycle. It aborts to IDLE with no data_valid, and data_out is unchanged.
- Config inputs changed mid-frame have no effect until the next start bit.
- Reset mid-frame: immediate return to IDLE; a partial frame is never reported.

Test Plan:
- 8 bits, no parity, 1 stop; send 0xA5 then stop=1 -> data_out=0x0A5, data_valid pulse 1 clk after stop strobe, all errors 0.
- 8 bits, even parity; send 0x37 (five 1s) with parity bit 1 -> par_err=0. Repeat with parity bit 0 -> par_err=1, data_out=0x037.
- 7 bits, odd parity, 2 stops; send 0x7F with parity bit 0, stops 1,0 -> par_err=0, stop_err=1, brk=0, data_out=0x07F.
- 8 bits, parity on; all-zero data, parity 0, stop 0 -> brk=1, stop_err=1, data_out=0x000.
- data_len=3 and data_len=12 -> frames are treated as 5 and 9 bits; 9-bit 0x1FF gives data_out=0x1FF.
- clear at bit 4 of a frame, then a good 0x5A frame -> no pulse for the aborted frame, one pulse with 0x05A. Repeat with rst_n low mid-frame -> all outputs 0, busy=0.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: assembles LSB-first data of run-time length from
// sampler strobes, checks optional parity and 1/2 stop bits, and flags line break.
module uart_rx_frame_check #(
    parameter int   MAX_WIDTH = 9,
    parameter int   MIN_WIDTH = 5,
    parameter logic EVEN      = 1'b0,
    parameter logic ODD       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic [3:0]           data_len,
    input  logic                 par_en,
    input  logic                 par_type,
    input  logic                 stop_two,
    output logic [MAX_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 stop_err,
    output logic                 brk,
    output logic                 busy
);

    localparam logic [3:0] MIN_LEN = 4'(MIN_WIDTH);
    localparam logic [3:0] MAX_LEN = 4'(MAX_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t               state;
    logic [MAX_WIDTH-1:0] shift_q;
    logic [3:0]           cnt_q;
    logic [3:0]           len_q;
    logic                 par_en_q;
    logic                 par_type_q;
    logic                 stop_two_q;
    logic                 acc_q;      // running XOR of the data bits
    logic                 zero_q;     // every bit so far (data, parity) was 0
    logic                 par_flag_q;
    logic                 stop_flag_q;
    logic                 brk_flag_q;

    logic [3:0]           len_clamped;
    logic                 par_bad;
    logic                 stop_next;
    logic [MAX_WIDTH-1:0] aligned;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        len_clamped = data_len;
        if (data_len < MIN_LEN)
            len_clamped = MIN_LEN;
        else if (data_len > MAX_LEN)
            len_clamped = MAX_LEN;

        par_bad = 1'b0;
        if (par_type_q == ODD)
            par_bad = (bit_in == acc_q);
        else if (par_type_q == EVEN)
            par_bad = (bit_in != acc_q);

        stop_next = stop_flag_q | ~bit_in;
        // Bits enter at the MSB end, so a short frame sits high and is shifted down.
        aligned   = shift_q >> (MAX_LEN - len_q);
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            len_q       <= MIN_LEN;
            par_en_q    <= 1'b0;
            par_type_q  <= EVEN;
            stop_two_q  <= 1'b0;
            acc_q       <= 1'b0;
            zero_q      <= 1'b0;
            par_flag_q  <= 1'b0;
            stop_flag_q <= 1'b0;
            brk_flag_q  <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            brk         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            brk        <= 1'b0;

            if (clear) begin
                state <= IDLE;
            end else if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            len_q       <= len_clamped;
                            par_en_q    <= par_en;
                            par_type_q  <= par_type;
                            stop_two_q  <= stop_two;
                            shift_q     <= '0;
                            cnt_q       <= '0;
                            acc_q       <= 1'b0;
                            zero_q      <= 1'b1;
                            par_flag_q  <= 1'b0;
                            stop_flag_q <= 1'b0;
                            brk_flag_q  <= 1'b0;
                            state       <= DATA;
                        end
                    end

                    DATA: begin
                        shift_q <= {bit_in, shift_q[MAX_WIDTH-1:1]};
                        acc_q   <= acc_q ^ bit_in;
                        zero_q  <= zero_q & ~bit_in;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == len_q - 4'd1)
                            state <= par_en_q ? PARITY : STOP1;
                    end

                    PARITY: begin
                        par_flag_q <= par_bad;
                        zero_q     <= zero_q & ~bit_in;
                        state      <= STOP1;
                    end

                    STOP1: begin
                        stop_flag_q <= stop_next;
                        brk_flag_q  <= zero_q & ~bit_in;
                        if (stop_two_q) begin
                            state <= STOP2;
                        end else begin
                            state      <= IDLE;
                            data_valid <= 1'b1;
                            data_out   <= aligned;
                            par_err    <= par_flag_q;
                            stop_err   <= stop_next;
                            brk        <= zero_q & ~bit_in;
                        end
                    end

                    STOP2: begin
                        stop_flag_q <= stop_next;
                        state       <= IDLE;
                        data_valid  <= 1'b1;
                        data_out    <= aligned;
                        par_err     <= par_flag_q;
                        stop_err    <= stop_next;
                        brk         <= brk_flag_q;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
